// File: rtl/demux8_capture.sv
// Serial-to-parallel capture: steers strobed bits into a byte and presents each
// completed byte through a double-buffered dout/dout_valid/dout_ack handshake.
module demux8_capture #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_strobe,
  input  logic       resync,
  output logic [2:0] sel,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ack,
  output logic       overrun
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;

  logic [2:0] pos;
  logic [7:0] byte_b;
  logic       complete;

  function automatic logic [2:0] pos_of(input logic [2:0] c);
    return MSB_FIRST ? (3'd7 - c) : c;
  endfunction

  assign pos = pos_of(cnt_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;
    byte_b       = sh_q;
    byte_b[pos]  = din;

    // Resync beats a coincident strobe but leaves the output buffer alone.
    if (resync) begin
      cnt_d     = 3'd0;
      sh_d      = 8'd0;
      overrun_d = 1'b0;
    end else if (din_strobe) begin
      if (cnt_q == 3'd7) begin
        complete = 1'b1;
        cnt_d    = 3'd0;
        sh_d     = 8'd0;
      end else begin
        sh_d[pos] = din;
        cnt_d     = cnt_q + 3'd1;
      end
    end

    // An ack arriving with a new byte frees the buffer just in time to take it.
    if (complete) begin
      if (!dout_valid_q) begin
        dout_d       = byte_b;
        dout_valid_d = 1'b1;
      end else if (dout_ack) begin
        dout_d = byte_b;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ack) begin
      dout_valid_d = 1'b0;
    end

    sel_d = pos_of(cnt_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      cnt_q        <= 3'd0;
      sh_q         <= 8'd0;
      sel_q        <= MSB_FIRST ? 3'd7 : 3'd0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule
